jtag_master: RTL and testbench
==============================

JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter REGISTER_SIZE, default 32: maximum DR shift length in bits, and RSP_DATA width.
REQ-002 Parameter IR_SIZE, default 4: instruction register length in bits.
REQ-003 Parameter STATE_SIZE, default 4: width of TAP state encoding.
REQ-004 One clock, CLK, input, 1: system clock; all logic on rising edge.
REQ-005 RST, input, 1: reset, asynchronous, active-high.
REQ-006 CMD_VALID, input, 1: command request.
REQ-007 CMD_READY, output, 1: command accepted when CMD_VALID and CMD_READY are both high on a CLK edge.
REQ-008 CMD_OP, input, 2: command opcode; 0 = RESET, 1 = SHIFT_IR, 2 = SHIFT_DR, 3 = reserved.
REQ-009 CMD_LEN, input, $clog2(REGISTER_SIZE)+1: DR shift length; 0 or any value greater than REGISTER_SIZE means REGISTER_SIZE; ignored for other ops.
REQ-010 CMD_DATA, input, REGISTER_SIZE: shift-in data, LSB first; SHIFT_IR uses bits [IR_SIZE-1:0].
REQ-011 RSP_VALID, output, 1: one-cycle pulse marking command completion.
REQ-012 RSP_DATA, output, REGISTER_SIZE: captured TDO bits, right-justified, unused upper bits 0; held until the next completion.
REQ-013 TCK, output, 1: generated JTAG clock.
REQ-014 TMS, output, 1: JTAG mode select.
REQ-015 TDI, output, 1: JTAG serial data out to the target.
REQ-016 TDO, input, 1: JTAG serial data from the target.
REQ-017 TAP_STATE, output, STATE_SIZE: mirrored TAP state of the target.

Function
REQ-018 Each JTAG bit SHALL take 2 CLK cycles: phase 0 drives TCK=0 and updates TMS/TDI; phase 1 drives TCK=1 and samples TDO on that rising TCK.
- TCK SHALL stay 0 whenever no bit is in progress.
REQ-019 Master FSM states SHALL be M_INIT, M_IDLE, M_HDR, M_SHIFT, M_TAIL, M_RSP.
REQ-020 RESET (and M_INIT) TMS sequence SHALL be 1,1,1,1,1,0: 6 TCK, ending in Run-Test/Idle.
REQ-021 SHIFT_IR SHALL drive:
- header TMS 1,1,0,0
- IR_SIZE data bits, TMS=0 except TMS=1 on the last
- tail TMS 1,0
REQ-022 SHIFT_DR SHALL drive:
- header TMS 1,0,0
- L data bits, TMS=1 on the last only
- tail TMS 1,0
REQ-023 During data bits, TDI SHALL be CMD_DATA bit i for data bit i. TDO sampled at data bit i SHALL land in RSP_DATA[i]. Outside data bits, TDI SHALL be 0.
REQ-024 RSP_VALID SHALL pulse in the CLK cycle after the phase 1 of the final tail bit. This gives completion latencies measured from the accept edge:
- RESET: 13 CLK
- SHIFT_IR with IR_SIZE=4: 21 CLK
- SHIFT_DR with L bits: 2*(L+5)+1 CLK
REQ-025 RESET SHALL leave RSP_DATA at 0.
REQ-026 CMD_READY SHALL be high only in M_IDLE; RSP_VALID SHALL precede the return to M_IDLE.
- Back-to-back accept is possible the cycle after RSP_VALID.
REQ-027 Opcode 3 SHALL be accepted, produce no TCK activity, and return RSP_VALID one cycle later with RSP_DATA unchanged.
REQ-028 TAP_STATE SHALL track the IEEE 1149.1 16-state TAP graph. It SHALL update on each phase 1 from the current TMS.
REQ-029 CMD_DATA, CMD_OP and the effective length SHALL be registered at accept; later input changes SHALL have no effect.

Reset
REQ-030 RST asserted SHALL immediately force:
- TCK=0, TMS=1, TDI=0
- CMD_READY=0, RSP_VALID=0, RSP_DATA=0
- TAP_STATE=TEST_LOGIC_RESET
- FSM=M_INIT
REQ-031 After RST deasserts, the block SHALL run the REQ-020 sequence, then enter M_IDLE with CMD_READY=1.
- No RSP_VALID for this sequence.
REQ-032 RST mid-command SHALL abort the command with no RSP_VALID.

Structure
REQ-033 Shared package jtag_pkg SHALL hold:
- 16-value TAP state enum (STATE_SIZE bits)
- opcode constants
- master FSM enum
REQ-034 Sub-module jtag_tap_tracker SHALL hold the TAP next-state logic and register; it is reused by the TAP model.

Verification
REQ-035 RST pulse, then release -> 6 TCK rising edges with TMS=1,1,1,1,1,0, then CMD_READY=1 with TAP_STATE=RUN_TEST_IDLE.
REQ-036 SHIFT_IR, CMD_DATA=0x8 -> TDI bits 0,0,0,1 in Shift-IR, then RSP_VALID 21 CLK after accept, then TAP_STATE=RUN_TEST_IDLE.
REQ-037 SHIFT_DR, LEN=0, CMD_DATA=0xA5A5_0F0F, TDO looped from TDI -> RSP_DATA=0xA5A5_0F0F, with 32 Shift-DR bits.
REQ-038 SHIFT_DR, LEN=1, TDO=1 -> RSP_DATA=0x1, then RSP_VALID 13 CLK after accept.
REQ-039 RST asserted at CLK 20 of a SHIFT_DR -> TCK=0 and TMS=1 at once, no RSP_VALID, then the re-init sequence.
REQ-040 CMD_VALID held high across three commands -> accepts only while CMD_READY=1, and each accept is followed by exactly one RSP_VALID.

Source files
------------

// File: rtl/jtag_pkg.sv
// JTAG master shared types.
// TAP state encoding, opcodes and master FSM states.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam logic [1:0] OP_RESET    = 2'd0;
  localparam logic [1:0] OP_SHIFT_IR = 2'd1;
  localparam logic [1:0] OP_SHIFT_DR = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  typedef enum logic [2:0] {
    M_INIT,
    M_IDLE,
    M_HDR,
    M_SHIFT,
    M_TAIL,
    M_RSP
  } mstate_e;

  // Header TMS patterns, bit 0 goes out first.
  localparam logic [5:0] SEQ_RESET = 6'b011111;
  localparam logic [5:0] SEQ_IR    = 6'b000011;
  localparam logic [5:0] SEQ_DR    = 6'b000001;

endpackage

// File: rtl/jtag_tap_tracker.sv
// IEEE 1149.1 TAP controller state tracker.
// Advances one state per enabled clock from the TMS value.
module jtag_tap_tracker
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e nxt;

  // Next state from the 16-state TAP graph.
  always_comb begin
    nxt = state;
    case (state)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      default:          nxt = TEST_LOGIC_RESET;
    endcase
  end

  // State register, moves only on a TCK rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TEST_LOGIC_RESET;
    else if (en) state <= nxt;
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG master: command-driven IR/DR scans.
// Two CLK cycles per TCK bit, TAP state mirrored locally.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int IR_SIZE       = 4,
  parameter int STATE_SIZE    = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic [1:0]                    CMD_OP,
  input  logic [$clog2(REGISTER_SIZE):0] CMD_LEN,
  input  logic [REGISTER_SIZE-1:0]      CMD_DATA,
  output logic                          RSP_VALID,
  output logic [REGISTER_SIZE-1:0]      RSP_DATA,
  output logic                          TCK,
  output logic                          TMS,
  output logic                          TDI,
  input  logic                          TDO,
  output logic [STATE_SIZE-1:0]         TAP_STATE
);

  localparam int IW = $clog2(REGISTER_SIZE);
  localparam int LW = IW + 1;
  localparam logic [LW-1:0] RS = LW'(REGISTER_SIZE);

  mstate_e                st;
  logic                   ph;
  logic [5:0]             seq;
  logic [2:0]             cnt;
  logic [1:0]             op;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          last;
  logic [IW-1:0]          nidx;
  logic [REGISTER_SIZE-1:0] dat;
  logic [REGISTER_SIZE-1:0] cap;
  logic [REGISTER_SIZE-1:0] rd_q;
  logic                   tck_q;
  logic                   tms_q;
  logic                   tdi_q;
  logic                   rdy_q;
  logic                   rv_q;
  logic                   busy;
  logic [LW-1:0]          lenm1;
  logic [IW-1:0]          dr_last;
  tap_state_e             tap;

  // Effective last DR bit index, clamped to the register size.
  always_comb begin
    lenm1   = CMD_LEN - LW'(1);
    dr_last = lenm1[IW-1:0];
    if (CMD_LEN == '0 || CMD_LEN > RS) dr_last = IW'(REGISTER_SIZE - 1);
  end

  assign busy = (st == M_INIT) || (st == M_HDR) ||
                (st == M_SHIFT) || (st == M_TAIL);
  assign nidx = idx + IW'(1);

  // Master sequencer: header, data bits, tail, response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st    <= M_INIT;
      ph    <= 1'b0;
      seq   <= SEQ_RESET;
      cnt   <= 3'd6;
      op    <= OP_RESET;
      idx   <= '0;
      last  <= '0;
      dat   <= '0;
      cap   <= '0;
      rd_q  <= '0;
      tck_q <= 1'b0;
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
      rdy_q <= 1'b0;
      rv_q  <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (st)
        M_IDLE: begin
          if (CMD_VALID) begin
            rdy_q <= 1'b0;
            op    <= CMD_OP;
            dat   <= CMD_DATA;
            cap   <= '0;
            idx   <= '0;
            last  <= (CMD_OP == OP_SHIFT_IR) ?
                     IW'(IR_SIZE - 1) : dr_last;
            tdi_q <= 1'b0;
            case (CMD_OP)
              OP_RESET: begin
                seq <= SEQ_RESET; cnt <= 3'd6;
                tms_q <= 1'b1; st <= M_HDR;
              end
              OP_SHIFT_IR: begin
                seq <= SEQ_IR; cnt <= 3'd4;
                tms_q <= 1'b1; st <= M_HDR;
              end
              OP_SHIFT_DR: begin
                seq <= SEQ_DR; cnt <= 3'd3;
                tms_q <= 1'b1; st <= M_HDR;
              end
              default: begin
                rv_q <= 1'b1;
                st   <= M_RSP;
              end
            endcase
          end
        end
        M_RSP: begin
          rdy_q <= 1'b1;
          st    <= M_IDLE;
        end
        default: begin
          if (!ph) begin
            ph    <= 1'b1;
            tck_q <= 1'b1;
            if (st == M_SHIFT) cap[idx] <= TDO;
          end else begin
            ph    <= 1'b0;
            tck_q <= 1'b0;
            case (st)
              M_INIT, M_HDR: begin
                if (cnt != 3'd1) begin
                  cnt   <= cnt - 3'd1;
                  seq   <= {1'b0, seq[5:1]};
                  tms_q <= seq[1];
                end else if (st == M_INIT) begin
                  st    <= M_IDLE;
                  rdy_q <= 1'b1;
                  tms_q <= 1'b0;
                end else if (op == OP_RESET) begin
                  st    <= M_RSP;
                  rv_q  <= 1'b1;
                  rd_q  <= '0;
                  tms_q <= 1'b0;
                end else begin
                  st    <= M_SHIFT;
                  tms_q <= (last == '0);
                  tdi_q <= dat[0];
                end
              end
              M_SHIFT: begin
                if (idx == last) begin
                  st    <= M_TAIL;
                  cnt   <= 3'd2;
                  tms_q <= 1'b1;
                  tdi_q <= 1'b0;
                end else begin
                  idx   <= nidx;
                  tms_q <= (nidx == last);
                  tdi_q <= dat[nidx];
                end
              end
              M_TAIL: begin
                if (cnt == 3'd2) begin
                  cnt   <= 3'd1;
                  tms_q <= 1'b0;
                end else begin
                  st   <= M_RSP;
                  rv_q <= 1'b1;
                  rd_q <= cap;
                end
              end
              default: st <= M_INIT;
            endcase
          end
        end
      endcase
    end
  end

  jtag_tap_tracker u_tap (
    .clk   (CLK),
    .rst   (RST),
    .en    (busy & ~ph),
    .tms   (tms_q),
    .state (tap)
  );

  assign CMD_READY = rdy_q;
  assign RSP_VALID = rv_q;
  assign RSP_DATA  = rd_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign TAP_STATE = STATE_SIZE'(tap);

endmodule

// File: tb/tb_jtag_master.sv
// jtag_master bench: scoreboard of responses,
// TCK-edge log of TMS/TDI checked per command.
module tb_jtag_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [1:0]  CMD_OP = 2'd0;
  logic [5:0]  CMD_LEN = 6'd0;
  logic [31:0] CMD_DATA = 32'd0;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic        TCK, TMS, TDI, TDO;
  logic [3:0]  TAP_STATE;
  logic        loopb = 1'b1;
  logic        tdo_v = 1'b0;

  assign TDO = loopb ? TDI : tdo_v;

  jtag_master dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .TAP_STATE(TAP_STATE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] data;
    int          at;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  bit log_tms[$], log_tdi[$], exp_tms[$], exp_tdi[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(posedge TCK) begin
    log_tms.push_back(TMS);
    log_tdi.push_back(TDI);
  end

  // Scoreboard monitor: every RSP_VALID must match a queued expectation.
  always @(negedge CLK) begin
    if (RSP_VALID === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp: got RSP_VALID=1 at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_data"}, RSP_DATA, e.data);
        chk({e.name, "_lat"}, 32'(cyc + 1), 32'(e.at));
      end
    end
  end

  task automatic add_seq(input logic [1:0] op, input int n,
                         input logic [31:0] d);
    case (op)
      2'd0: for (int i = 0; i < 6; i++) begin
        exp_tms.push_back(i < 5); exp_tdi.push_back(1'b0);
      end
      2'd1, 2'd2: begin
        for (int i = 0; i < ((op == 2'd1) ? 4 : 3); i++) begin
          exp_tms.push_back((op == 2'd1) ? (i < 2) : (i == 0));
          exp_tdi.push_back(1'b0);
        end
        for (int i = 0; i < n; i++) begin
          exp_tms.push_back(i == n - 1); exp_tdi.push_back(d[i]);
        end
        exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0);
        exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic check_log(input string nm);
    int bad = -1;
    checks++;
    if (log_tms.size() != exp_tms.size()) bad = 9999;
    else
      for (int i = 0; i < exp_tms.size(); i++)
        if (bad < 0 && (log_tms[i] != exp_tms[i] || log_tdi[i] != exp_tdi[i]))
          bad = i;
    if (bad < 0) passes++;
    else $display("FAIL %s_seq: got %0d tck bits expected %0d, first diff at %0d",
                  nm, log_tms.size(), exp_tms.size(), bad);
    log_tms.delete(); log_tdi.delete();
    exp_tms.delete(); exp_tdi.delete();
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 300) begin
      @(negedge CLK); n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL %s_ready_timeout: got CMD_READY=%b expected 1", nm, CMD_READY);
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((sbq.size() != 0 || CMD_READY !== 1'b1) && n < 300) begin
      @(negedge CLK); n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL %s_done_timeout: got %0d pending expected 0", nm, sbq.size());
    end
    chk({nm, "_tap"}, 32'(TAP_STATE), 32'hC);
    check_log(nm);
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] len,
                      input logic [31:0] d, input logic [31:0] ed,
                      input int lat, input string nm, input int nb);
    @(negedge CLK);
    CMD_OP = op; CMD_LEN = len; CMD_DATA = d; CMD_VALID = 1'b1;
    wait_ready(nm);
    sbq.push_back('{ed, cyc + 1 + lat, nm});
    add_seq(op, nb, d);
    @(negedge CLK);
    CMD_VALID = 1'b0; CMD_DATA = ~d; CMD_OP = 2'd2; CMD_LEN = 6'd7;
    wait_done(nm);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    @(negedge CLK);
    chk("rst_tck", 32'(TCK), 32'd0);
    chk("rst_tms", 32'(TMS), 32'd1);
    chk("rst_tdi", 32'(TDI), 32'd0);
    chk("rst_ready", 32'(CMD_READY), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_data", RSP_DATA, 32'd0);
    chk("rst_tap", 32'(TAP_STATE), 32'hF);
    RST = 1'b0;
    add_seq(2'd0, 0, 32'd0);
    wait_done("init");

    send(2'd1, 6'd0, 32'h8, 32'h8, 21, "ir8", 4);
    send(2'd2, 6'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 75, "dr32", 32);
    send(2'd3, 6'd5, 32'h1111_2222, 32'hA5A5_0F0F, 1, "op3", 0);
    loopb = 1'b0; tdo_v = 1'b1;
    send(2'd2, 6'd1, 32'h0, 32'h1, 13, "dr1", 1);
    send(2'd2, 6'd8, 32'h0, 32'hFF, 27, "dr8", 8);
    loopb = 1'b1;
    send(2'd0, 6'd0, 32'hFFFF_FFFF, 32'h0, 13, "reset_op", 0);
    send(2'd2, 6'd40, 32'h1234_5678, 32'h1234_5678, 75, "dr40", 32);
    send(2'd2, 6'd32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 75, "dr32b", 32);

    @(negedge CLK);
    CMD_OP = 2'd2; CMD_LEN = 6'd0; CMD_DATA = 32'hFFFF_0000;
    CMD_VALID = 1'b1;
    wait_ready("abort");
    acc = cyc + 1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    while (cyc < acc + 19) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_tck", 32'(TCK), 32'd0);
    chk("abort_tms", 32'(TMS), 32'd1);
    chk("abort_ready", 32'(CMD_READY), 32'd0);
    chk("abort_rsp_data", RSP_DATA, 32'd0);
    chk("abort_tap", 32'(TAP_STATE), 32'hF);
    log_tms.delete(); log_tdi.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    add_seq(2'd0, 0, 32'd0);
    wait_done("reinit");

    @(negedge CLK);
    CMD_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin CMD_OP = 2'd2; CMD_LEN = 6'd4; CMD_DATA = 32'hB; end
        1: begin CMD_OP = 2'd3; CMD_LEN = 6'd0; CMD_DATA = 32'h0; end
        default: begin CMD_OP = 2'd0; CMD_LEN = 6'd0; CMD_DATA = 32'h0; end
      endcase
      wait_ready("b2b");
      case (k)
        0: begin sbq.push_back('{32'hB, cyc + 1 + 19, "b2b_dr4"}); add_seq(2'd2, 4, 32'hB); end
        1: sbq.push_back('{32'hB, cyc + 1 + 1, "b2b_op3"});
        default: begin sbq.push_back('{32'h0, cyc + 1 + 13, "b2b_reset"}); add_seq(2'd0, 0, 32'd0); end
      endcase
      @(negedge CLK);
      chk("b2b_ready_drop", 32'(CMD_READY), 32'd0);
    end
    CMD_VALID = 1'b0;
    wait_done("b2b");

    repeat (5) @(negedge CLK);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
